// File: rtl/sr_pkg.sv
// rtl/sr_pkg.sv - simultaneous set/reset policy codes and the shared next-state function
package sr_pkg;

  typedef logic [1:0] sr_policy_t;

  localparam sr_policy_t SR_RESET_DOM = 2'd0;
  localparam sr_policy_t SR_SET_DOM   = 2'd1;
  localparam sr_policy_t SR_HOLD      = 2'd2;
  localparam sr_policy_t SR_TOGGLE    = 2'd3;

  function automatic logic sr_next(input logic q, input logic s, input logic r,
                                   input sr_policy_t policy);
    logic nxt;
    nxt = q;
    case ({s, r})
      2'b00: nxt = q;
      2'b01: nxt = 1'b0;
      2'b10: nxt = 1'b1;
      default: begin
        case (policy)
          SR_RESET_DOM: nxt = 1'b0;
          SR_SET_DOM:   nxt = 1'b1;
          SR_HOLD:      nxt = q;
          default:      nxt = ~q;
        endcase
      end
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/sr_cell.sv
// rtl/sr_cell.sv - single SR storage bit with a registered set/reset conflict flag
module sr_cell
  import sr_pkg::*;
#(
  parameter logic       RESET_VALUE = 1'b0,
  parameter sr_policy_t POLICY      = SR_RESET_DOM
) (
  input  logic clk,
  input  logic rst,
  input  logic s,
  input  logic r,
  output logic q,
  output logic conflict
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q        <= RESET_VALUE;
      conflict <= 1'b0;
    end else begin
      q        <= sr_next(q, s, r, POLICY);
      conflict <= s & r;
    end
  end

endmodule

// File: rtl/sr_flip_flop.sv
// rtl/sr_flip_flop.sv - bank of WIDTH independent clocked SR flip-flops
module sr_flip_flop
  import sr_pkg::*;
#(
  parameter int unsigned      WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int unsigned      BOTH_POLICY = SR_RESET_DOM
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic [WIDTH-1:0] conflict
);

  if (BOTH_POLICY > 32'(SR_TOGGLE)) begin : g_bad_policy
    $error("sr_flip_flop: illegal BOTH_POLICY value %0d", BOTH_POLICY);
  end

  localparam sr_policy_t POLICY = sr_policy_t'(BOTH_POLICY);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    sr_cell #(
      .RESET_VALUE (RESET_VALUE[i]),
      .POLICY      (POLICY)
    ) u_cell (
      .clk      (clk),
      .rst      (rst),
      .s        (s[i]),
      .r        (r[i]),
      .q        (q[i]),
      .conflict (conflict[i])
    );
  end

  assign qn = ~q;

endmodule

// File: tb/tb_sr_flip_flop.sv
// tb/tb_sr_flip_flop.sv - directed self-checking bench for sr_flip_flop across policies and widths
module tb_sr_flip_flop;
  import sr_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic s, r;
  logic [3:0] s4, r4;

  logic q_rd, qn_rd, cf_rd;
  logic q_sd, qn_sd, cf_sd;
  logic q_hd, qn_hd, cf_hd;
  logic q_tg, qn_tg, cf_tg;
  logic [3:0] q4, qn4, cf4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sr_flip_flop #(.WIDTH(1), .RESET_VALUE(1'b0), .BOTH_POLICY(SR_RESET_DOM)) u_rd (
    .clk(clk), .rst(rst), .s(s), .r(r), .q(q_rd), .qn(qn_rd), .conflict(cf_rd));
  sr_flip_flop #(.WIDTH(1), .RESET_VALUE(1'b0), .BOTH_POLICY(SR_SET_DOM)) u_sd (
    .clk(clk), .rst(rst), .s(s), .r(r), .q(q_sd), .qn(qn_sd), .conflict(cf_sd));
  sr_flip_flop #(.WIDTH(1), .RESET_VALUE(1'b0), .BOTH_POLICY(SR_HOLD)) u_hd (
    .clk(clk), .rst(rst), .s(s), .r(r), .q(q_hd), .qn(qn_hd), .conflict(cf_hd));
  sr_flip_flop #(.WIDTH(1), .RESET_VALUE(1'b0), .BOTH_POLICY(SR_TOGGLE)) u_tg (
    .clk(clk), .rst(rst), .s(s), .r(r), .q(q_tg), .qn(qn_tg), .conflict(cf_tg));
  sr_flip_flop #(.WIDTH(4), .RESET_VALUE(4'b1010), .BOTH_POLICY(SR_RESET_DOM)) u_w4 (
    .clk(clk), .rst(rst), .s(s4), .r(r4), .q(q4), .qn(qn4), .conflict(cf4));

  task automatic check_eq(input string tag, input logic [3:0] got, input logic [3:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%b expected=%b", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_single(input string tag, input logic exp_q, input logic exp_cf);
    check_eq({tag, ".q"},  {3'b0, q_rd},  {3'b0, exp_q});
    check_eq({tag, ".qn"}, {3'b0, qn_rd}, {3'b0, ~exp_q});
    check_eq({tag, ".cf"}, {3'b0, cf_rd}, {3'b0, exp_cf});
  endtask

  initial begin
    rst = 1'b1; s = 1'b0; r = 1'b0; s4 = 4'b0; r4 = 4'b0;
    step();
    check_single("reset", 1'b0, 1'b0);
    check_eq("reset.q4", q4, 4'b1010);
    check_eq("reset.cf4", cf4, 4'b0000);

    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_single($sformatf("hold%0d", i), 1'b0, 1'b0);
    end
    check_eq("hold.q4", q4, 4'b1010);

    // basic sequence on the reset-dominant bit
    r = 1'b1; step(); check_single("clr", 1'b0, 1'b0);
    s = 1'b1; r = 1'b0; step(); check_single("set", 1'b1, 1'b0);
    s = 1'b0; step(); check_single("hold_one", 1'b1, 1'b0);

    // every single-bit instance now holds 1: apply s=r=1 once
    s = 1'b1; r = 1'b1; step();
    check_single("both_rd", 1'b0, 1'b1);
    check_eq("both_sd.q", {3'b0, q_sd}, 4'b0001);
    check_eq("both_hd.q", {3'b0, q_hd}, 4'b0001);
    check_eq("both_tg.q", {3'b0, q_tg}, 4'b0000);
    check_eq("both_sd.cf", {3'b0, cf_sd}, 4'b0001);
    s = 1'b0; r = 1'b0; step();
    check_single("cf_clear", 1'b0, 1'b0);

    // toggle held for three edges from q=1
    s = 1'b1; r = 1'b0; step();
    check_eq("tg_pre", {3'b0, q_tg}, 4'b0001);
    s = 1'b1; r = 1'b1;
    step(); check_eq("tg1", {3'b0, q_tg}, 4'b0000);
    step(); check_eq("tg2", {3'b0, q_tg}, 4'b0001);
    step(); check_eq("tg3", {3'b0, q_tg}, 4'b0000);
    check_eq("tg3.cf", {3'b0, cf_tg}, 4'b0001);
    check_eq("tg3.qn", {3'b0, qn_tg}, 4'b0001);

    // reset priority over pending set and toggle
    s = 1'b1; r = 1'b0; step();
    check_single("pre_rst", 1'b1, 1'b0);
    s = 1'b1; r = 1'b1; step();
    check_eq("pre_rst.cf", {3'b0, cf_rd}, 4'b0001);
    rst = 1'b1; s = 1'b1; r = 1'b0; step();
    check_single("rst_prio", 1'b0, 1'b0);
    check_eq("rst_prio.sd", {3'b0, q_sd}, 4'b0000);
    check_eq("rst_prio.tg", {3'b0, q_tg}, 4'b0000);
    rst = 1'b0; step();
    check_single("rst_release", 1'b1, 1'b0);

    // multi-bit independence
    rst = 1'b1; s = 1'b0; r = 1'b0; step();
    check_eq("w4.reset", q4, 4'b1010);
    rst = 1'b0; s4 = 4'b0101; r4 = 4'b1000; step();
    check_eq("w4.q", q4, 4'b0111);
    check_eq("w4.qn", qn4, 4'b1000);
    check_eq("w4.cf", cf4, 4'b0000);
    s4 = 4'b0011; r4 = 4'b0110; step();
    check_eq("w4.mix.q", q4, 4'b0001);
    check_eq("w4.mix.cf", cf4, 4'b0010);
    s4 = 4'b0000; r4 = 4'b0000; step();
    check_eq("w4.hold.q", q4, 4'b0001);
    check_eq("w4.hold.cf", cf4, 4'b0000);

    // glitch on s entirely between two rising edges
    check_single("pre_glitch", 1'b0, 1'b0);
    #1 s = 1'b1;
    #2 s = 1'b0;
    step();
    check_single("glitch", 1'b0, 1'b0);
    check_eq("glitch.sd", {3'b0, q_sd}, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
